// File: rtl/tcam_match_resolver_if.sv
// Handshake bundle between a TCAM match source and the match resolver.
// The input side carries one match vector per transaction. The output side
// carries one resolved entry per beat.
interface tcam_match_resolver_if #(
    parameter int N = 16,
    parameter int W = $clog2(N)
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] match_vec;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_hit;
    logic         out_last;
    logic [W:0]   out_count;

    // Producer of match vectors and consumer of resolved beats.
    modport master (
        output in_valid, match_vec, in_mode, out_ready,
        input  in_ready, out_valid, out_idx, out_hit, out_last, out_count
    );

    // The resolver itself.
    modport slave (
        input  in_valid, match_vec, in_mode, out_ready,
        output in_ready, out_valid, out_idx, out_hit, out_last, out_count
    );
endinterface

// File: rtl/tcam_match_resolver.sv
// TCAM match-line resolver. It captures one match vector per transaction and
// reports the highest-index matching entry. In enumerate mode it reports every
// matching entry in descending index order, one beat each. All out_* fields
// are decoded from registered state only.
module tcam_match_resolver #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tcam_match_resolver_if.slave  bus
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state;
    logic [N-1:0] pending;
    logic         mode_q;
    logic [W:0]   count_q;

    logic [W-1:0] top_idx;
    logic         last_beat;
    logic         take;

    // Highest set bit wins. An empty vector encodes to 0.
    function automatic logic [W-1:0] prio_enc(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = W'(i);
        end
        return r;
    endfunction

    // Number of set match lines. W+1 bits always holds N.
    function automatic logic [W:0] popcount(input logic [N-1:0] v);
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + {{W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign top_idx = prio_enc(pending);

    // A beat is final in three cases: first-only mode, no bits left, or one bit left.
    // The test v & (v-1) == 0 covers both the zero-bit and the one-bit cases.
    assign last_beat = !mode_q ||
                       ((pending & (pending - {{(N-1){1'b0}}, 1'b1})) == '0);

    assign bus.out_valid = (state == EMIT);
    assign bus.out_idx   = top_idx;
    assign bus.out_hit   = |pending;
    assign bus.out_last  = last_beat;
    assign bus.out_count = count_q;

    // A new vector may also load on the edge that retires the final beat.
    // This gives back-to-back transactions.
    assign bus.in_ready = (state == IDLE) || (bus.out_ready && last_beat);
    assign take         = bus.in_valid && bus.in_ready;

    // Capture, iterate over pending matches, and retire transactions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            mode_q  <= 1'b0;
            count_q <= '0;
        end else if (take) begin
            state   <= EMIT;
            pending <= bus.match_vec;
            mode_q  <= bus.in_mode;
            count_q <= popcount(bus.match_vec);
        end else if (state == EMIT && bus.out_ready) begin
            if (last_beat) begin
                state   <= IDLE;
                pending <= '0;
                mode_q  <= 1'b0;
                count_q <= '0;
            end else begin
                pending[top_idx] <= 1'b0;
            end
        end
    end
endmodule

// File: doc/tcam_match_resolver.md
# tcam_match_resolver

Parametrised, handshaked match-line resolver for the TCAM datapath. It accepts one N-bit match vector per transaction and returns the highest-index matching entry, or, in enumerate mode, every matching entry in descending index order, one per beat. It replaces the fixed 16-to-4 combinational priority encoder. It adds input/output valid-ready flow control, a hit flag, a match count, and multi-match iteration.

## Interface

- N, default 16: number of match lines; must be at least 2 (power of two not required).
- W, default $clog2(N): index width.
- clk  in  1: rising-edge clock.
- rst_n  in  1: synchronous, active-low reset.
- in_valid  in  1: match_vec and in_mode are valid.
- in_ready  out  1: resolver can accept a vector this cycle.
- match_vec  in  N: TCAM match lines; bit i = entry i matched.
- in_mode  in  1: 0 = first-only, 1 = enumerate all matches.
- out_valid  out  1: out_* fields are valid.
- out_ready  in  1: downstream accepts the current beat.
- out_idx  out  W: index of the highest set bit remaining; 0 when out_hit = 0.
- out_hit  out  1: at least one match remains in this beat.
- out_last  out  1: final beat of the transaction.
- out_count  out  W+1: popcount of the captured vector, constant for all beats of a transaction.

## Operation

- Priority: the highest index wins (bit N-1 highest), matching the legacy encoder.
- State machine has two states, IDLE and EMIT.
- Internal registers: pending[N-1:0], mode_q, count_q.

IDLE:
- in_ready = 1; out_valid = 0.
- On in_valid: pending <= match_vec, mode_q <= in_mode, count_q <= popcount(match_vec), then go to EMIT.

EMIT:
- out_valid = 1.
- out_idx = priority encode of pending.
- out_hit = |pending.
- out_count = count_q.
- out_last = 1 when any of these holds: mode_q = 0, pending = 0, or pending has exactly one bit set.

Beat acceptance (out_valid & out_ready):
- If out_last: the transaction ends. Go to IDLE, unless a new vector is captured in the same cycle (see below).
- Otherwise: clear pending[out_idx] and stay in EMIT.

Other rules:
- in_ready = (state == IDLE) or (state == EMIT & out_ready & out_last). This allows back-to-back transactions.
- Same-cycle capture: when a last beat is accepted and in_valid = 1 in the same cycle, the new vector loads and the state stays EMIT.
- No match: exactly one beat is emitted, with out_hit = 0, out_idx = 0, out_last = 1, out_count = 0.
- First-only mode: exactly one beat per transaction, regardless of how many bits are set.
- Enumerate mode with M ≥ 1 matches: exactly M beats, with strictly descending out_idx; out_last is set only on the M-th beat.
- Backpressure: while out_valid & !out_ready, all out_* fields hold stable and pending is unchanged.
- match_vec and in_mode are sampled only on the capture edge; changes outside it are ignored.
- out_count arithmetic: W+1 bits, saturation impossible (the maximum value N fits).

## Timing

- Reset (rst_n = 0 at a rising edge): state = IDLE, pending = 0, mode_q = 0, count_q = 0.
- Resulting output values after reset: out_valid = 0, out_idx = 0, out_hit = 0, out_last = 1, out_count = 0, in_ready = 1.
- Reset mid-transaction: the transaction is dropped with no further beats, and the resolver is back in IDLE on the next cycle.
- Latency: a vector captured at edge k makes out_valid = 1 in the cycle following edge k, i.e. one cycle of latency.
- Throughput:
  - First-only mode, or no match, with out_ready held at 1: one transaction per cycle.
  - Enumerate mode: M beats per transaction; the next vector is captured on the edge that accepts the last beat.
- Outputs are decoded from registers only; there is no combinational path from match_vec to out_*.
- Combinational paths that do exist:
  - in_ready depends on out_ready.
  - out_valid does not depend on in_valid.

## Test plan

- Reset, then N=16, first-only mode, match_vec = 16'h0A10 with out_ready = 1 -> one beat: out_idx = 11, out_hit = 1, out_last = 1, out_count = 3, one cycle after capture.
- Enumerate mode, match_vec = 16'h8421, out_ready = 1 -> four consecutive beats with out_idx = 15, 10, 5, 0; out_last = 1 only on idx 0; out_count = 4 on every beat.
- match_vec = 16'h0000, either mode -> one beat: out_hit = 0, out_idx = 0, out_last = 1, out_count = 0.
- Backpressure: enumerate 16'h0006, out_ready = 0 for 3 cycles -> out_idx holds 2 and in_ready = 0. Then set out_ready = 1 -> beats 2, 1.
- Back-to-back: first-only vectors 16'h0001, 16'h8000, 16'h0100 on consecutive cycles with in_valid and out_ready high -> out_idx = 0, 15, 8 on consecutive cycles, with in_ready held at 1.
- Reset mid-op: enumerate 16'hFFFF, assert rst_n = 0 after the third beat -> out_valid = 0 the next cycle and in_ready = 1. A new vector 16'h0002 then yields out_idx = 1.
